// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data-memory responder.
package dmem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dmem_state_t;

   localparam int unsigned DMEM_LATENCY    = 4;
   localparam int unsigned DMEM_DEPTH_LOG2 = 12;
   localparam int unsigned DMEM_ADDR_W     = 16;
   localparam int unsigned DMEM_DATA_W     = 16;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: registered read, write-first.
module dmem_array #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Write-first port: a write forwards the new word onto the read register.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
         rdata     <= wdata;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with valid/ready request and pulsed response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DMEM_ADDR_W,
   parameter int unsigned DATA_W     = DMEM_DATA_W,
   parameter int unsigned DEPTH_LOG2 = DMEM_DEPTH_LOG2,
   parameter int unsigned LATENCY    = DMEM_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_wr,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata
);

   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dmem_state_t state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic accept, access;

   logic                  cap_wr, cap_odd;
   logic [DEPTH_LOG2-1:0] cap_idx;
   logic [DATA_W-1:0]     cap_wdata;

   logic                  acc_wr, acc_odd;
   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [DATA_W-1:0]     acc_wdata;

   logic                  ram_we;
   logic [DATA_W-1:0]     ram_rdata;

   // Read data is the RAM read register right after a load, else the held copy.
   logic                  rdata_sel;
   logic [DATA_W-1:0]     rdata_hold;

   // Address bits above the word index alias and are intentionally dropped.
   logic unused_addr_hi;
   generate
      if (ADDR_W > DEPTH_LOG2 + 1) begin : g_addr_hi
         assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2+1];
      end else begin : g_no_addr_hi
         assign unused_addr_hi = 1'b0;
      end
   endgenerate

   // State and counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state, counter and access strobes.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      accept     = 1'b0;
      access     = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept   = 1'b1;
               next_cnt = CNT_LOAD;
               if (LATENCY == 1) begin
                  access = 1'b1;
               end else begin
                  next_state = BUSY;
               end
            end
         end
         BUSY: begin
            next_cnt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               access     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // In IDLE the access (LATENCY 1 only) uses the live request, else the captured one.
   always_comb begin
      acc_wr    = cap_wr;
      acc_odd   = cap_odd;
      acc_idx   = cap_idx;
      acc_wdata = cap_wdata;
      if (state == IDLE) begin
         acc_wr    = req_wr;
         acc_odd   = req_addr[0];
         acc_idx   = req_addr[DEPTH_LOG2:1];
         acc_wdata = req_wdata;
      end
   end

   assign ram_we = access & acc_wr & ~acc_odd & ~rst;

   dmem_array #(
      .AW (DEPTH_LOG2),
      .DW (DATA_W)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign rsp_rdata = rdata_sel ? ram_rdata : rdata_hold;

   // Request capture, ready flag and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_wr     <= 1'b0;
         rsp_err    <= 1'b0;
         rdata_sel  <= 1'b0;
         rdata_hold <= '0;
         cap_wr     <= 1'b0;
         cap_odd    <= 1'b0;
         cap_idx    <= '0;
         cap_wdata  <= '0;
      end else begin
         req_ready  <= (next_state == IDLE);
         rsp_valid  <= access;
         rdata_hold <= rsp_rdata;
         rdata_sel  <= access & ~acc_wr & ~acc_odd;
         if (access) begin
            rsp_wr  <= acc_wr;
            rsp_err <= acc_odd;
         end
         if (accept) begin
            cap_wr    <= req_wr;
            cap_odd   <= req_addr[0];
            cap_idx   <= req_addr[DEPTH_LOG2:1];
            cap_wdata <= req_wdata;
         end
      end
   end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed table, hand sequences and random traffic vs a word-map model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // LATENCY 4 instance
   logic        rst4, valid4, ready4, wr4, rvalid4, rwr4, rerr4;
   logic [15:0] addr4, wdata4, rdata4;
   // LATENCY 1 instance
   logic        rst1, valid1, ready1, wr1, rvalid1, rwr1, rerr1;
   logic [15:0] addr1, wdata1, rdata1;

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst4), .req_valid(valid4), .req_ready(ready4), .req_wr(wr4),
      .req_addr(addr4), .req_wdata(wdata4), .rsp_valid(rvalid4), .rsp_wr(rwr4),
      .rsp_err(rerr4), .rsp_rdata(rdata4));

   dmem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(12), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1), .req_wr(wr1),
      .req_addr(addr1), .req_wdata(wdata1), .rsp_valid(rvalid1), .rsp_wr(rwr1),
      .rsp_err(rerr1), .rsp_rdata(rdata1));

   int errors = 0;
   int checks = 0;

   // Reference model for the LATENCY 4 instance: word map plus last load data.
   logic [15:0] model_mem [int];
   logic [15:0] model_rdata;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      bit          exp_err;
      logic [15:0] exp_rdata;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Applies one request to the model and returns the expected response fields.
   task automatic model_apply(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                              output bit err, output logic [15:0] rd);
      int idx;
      idx = int'(addr[12:1]);
      err = addr[0];
      if (!err) begin
         if (wr) model_mem[idx] = wdata;
         else if (model_mem.exists(idx)) model_rdata = model_mem[idx];
         else model_rdata = 16'hxxxx;
      end
      rd = model_rdata;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Issues one request on the LATENCY 4 instance in the current cycle and checks its response.
   task automatic do_req4(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit junk, input bit exp_err, input logic [15:0] exp_rdata);
      int n, ready_low;
      bit seen;
      check("ready_at_issue", 32'(ready4), 32'd1);
      valid4 = 1'b1; wr4 = wr; addr4 = addr; wdata4 = wdata;
      n = 0; ready_low = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         step();
         n++;
         if (rvalid4) begin
            seen = 1'b1;
         end else begin
            if (!ready4) ready_low++;
            if (junk) begin
               valid4 = 1'b1; wr4 = 1'($urandom); addr4 = 16'($urandom); wdata4 = 16'($urandom);
            end else begin
               valid4 = 1'b0;
            end
         end
      end
      valid4 = 1'b0;
      check("rsp_latency", 32'(n), 32'd4);
      check("busy_ready_low", 32'(ready_low), 32'd3);
      if (seen) begin
         check("rsp_wr", 32'(rwr4), 32'(wr));
         check("rsp_err", 32'(rerr4), 32'(exp_err));
         if (exp_rdata !== 16'hxxxx) check("rsp_rdata", 32'(rdata4), 32'(exp_rdata));
      end
   endtask

   // Model-driven request: expectation comes from the reference model.
   task automatic model_req4(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                             input bit junk);
      bit e;
      logic [15:0] rd;
      model_apply(wr, addr, wdata, e, rd);
      do_req4(wr, addr, wdata, junk, e, rd);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit          e;
      logic [15:0] rd;
      int          pulses;

      tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
      tbl[1] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF};
      tbl[2] = '{1'b0, 16'h0011, 16'h0000, 1'b1, 16'hBEEF};
      tbl[3] = '{1'b1, 16'h0020, 16'h5A5A, 1'b0, 16'hBEEF};
      tbl[4] = '{1'b1, 16'h0021, 16'h1234, 1'b1, 16'hBEEF};
      tbl[5] = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5A5A};
      tbl[6] = '{1'b0, 16'h2020, 16'h0000, 1'b0, 16'h5A5A};
      tbl[7] = '{1'b1, 16'h0040, 16'h7777, 1'b0, 16'h5A5A};
      tbl[8] = '{1'b0, 16'h0040, 16'h0000, 1'b0, 16'h7777};

      model_rdata = 16'h0000;
      rst4 = 1'b1; rst1 = 1'b1;
      valid4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
      valid1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      step(); step();

      check("reset_ready", 32'(ready4), 32'd1);
      check("reset_rsp_valid", 32'(rvalid4), 32'd0);
      check("reset_rsp_wr", 32'(rwr4), 32'd0);
      check("reset_rsp_err", 32'(rerr4), 32'd0);
      check("reset_rsp_rdata", 32'(rdata4), 32'd0);
      check("reset1_rsp_valid", 32'(rvalid1), 32'd0);
      rst4 = 1'b0; rst1 = 1'b0;

      // Directed table, issued back-to-back in each response cycle.
      for (int i = 0; i < 9; i++) begin
         do_req4(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].exp_err, tbl[i].exp_rdata);
         model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata, e, rd);
      end

      // Request held with changing address while busy: one service, one pulse.
      model_req4(1'b0, 16'h0010, 16'h0000, 1'b1);
      check("junk_served_rdata", 32'(rdata4), 32'h0000BEEF);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rvalid4) pulses++;
      end
      check("junk_extra_pulses", 32'(pulses), 32'd0);

      // Reset in cycle 2 of a store drops it entirely.
      valid4 = 1'b1; wr4 = 1'b1; addr4 = 16'h0040; wdata4 = 16'hAAAA;
      step();
      valid4 = 1'b0;
      step();
      rst4 = 1'b1;
      step();
      rst4 = 1'b0;
      check("abort_ready", 32'(ready4), 32'd1);
      check("abort_rsp_valid", 32'(rvalid4), 32'd0);
      check("abort_rsp_wr", 32'(rwr4), 32'd0);
      check("abort_rsp_err", 32'(rerr4), 32'd0);
      check("abort_rsp_rdata", 32'(rdata4), 32'd0);
      model_rdata = 16'h0000;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (rvalid4) pulses++;
      end
      check("abort_no_response", 32'(pulses), 32'd0);
      model_req4(1'b0, 16'h0040, 16'h0000, 1'b0);

      // Random traffic: prefill a small window, then mixed accesses with aliasing and gaps.
      for (int i = 0; i < 16; i++) begin
         model_req4(1'b1, 16'(16'h0400 + 2 * i), 16'($urandom), 1'b0);
      end
      for (int n = 0; n < 40; n++) begin
         int gap;
         logic [15:0] a;
         a = 16'((($urandom_range(0, 7)) << 13) | ((32'h200 + $urandom_range(0, 15)) << 1)
                 | (($urandom_range(0, 3) == 0) ? 1 : 0));
         model_req4(1'($urandom), a, 16'($urandom), 1'($urandom));
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step();
      end

      // LATENCY 1 instance: back-to-back stores then back-to-back loads.
      valid1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h1111;
      step();
      check("l1_store_a_valid", 32'(rvalid1), 32'd1);
      addr1 = 16'h0004; wdata1 = 16'h2222;
      step();
      check("l1_store_b_valid", 32'(rvalid1), 32'd1);
      check("l1_store_b_wr", 32'(rwr1), 32'd1);
      valid1 = 1'b0;
      step();
      check("l1_idle_valid", 32'(rvalid1), 32'd0);
      valid1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0002;
      step();
      check("l1_load_a_valid", 32'(rvalid1), 32'd1);
      check("l1_load_a_rdata", 32'(rdata1), 32'h1111);
      addr1 = 16'h0004;
      step();
      check("l1_load_b_valid", 32'(rvalid1), 32'd1);
      check("l1_load_b_rdata", 32'(rdata1), 32'h2222);
      check("l1_load_b_wr", 32'(rwr1), 32'd0);
      valid1 = 1'b0;
      step();
      check("l1_after_valid", 32'(rvalid1), 32'd0);
      check("l1_after_rdata_held", 32'(rdata1), 32'h2222);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dmem_responder
